// File: rtl/neuron_mac_seq.sv
// Sequential fixed-point neuron: one signed multiply-accumulate per cycle over
// captured operands, then bias-aware rounding toward -inf, optional ReLU and saturation.
module neuron_mac_seq #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FRAC_BITS  = 5,
    parameter bit          USE_RELU   = 1'b1
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]  VALUES_IN,
    input  logic                              VALID_IN,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]  WEIGHTS_IN,
    input  logic [WIDTH-1:0]                  BIAS_IN,
    output logic [WIDTH-1:0]                  VALUE_OUT,
    output logic                              VALID_OUT,
    output logic                              BUSY,
    output logic                              OVERRUN
);

    localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
    localparam logic signed [WIDTH-1:0] MAX_W    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX_ACC  = ACC_W'(MAX_W);
    localparam logic signed [ACC_W-1:0] MIN_ACC  = ACC_W'(MIN_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                           state_r,   state_nxt_s;
    logic [IDX_W-1:0]                 idx_r,     idx_nxt_s;
    logic signed [ACC_W-1:0]          acc_r,     acc_nxt_s;
    logic [NUM_INPUTS-1:0][WIDTH-1:0] vals_r,    vals_nxt_s;
    logic [NUM_INPUTS-1:0][WIDTH-1:0] wts_r,     wts_nxt_s;
    logic [WIDTH-1:0]                 value_r,   value_nxt_s;
    logic                             valid_r,   valid_nxt_s;
    logic                             overrun_r, overrun_nxt_s;

    logic signed [ACC_W-1:0]  bias_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [ACC_W-1:0]  relu_s;
    logic [WIDTH-1:0]         result_s;

    // Datapath arithmetic: scaled bias, current product, and the final result conversion.
    always_comb begin
        bias_ext_s = {{(ACC_W-WIDTH){BIAS_IN[WIDTH-1]}}, BIAS_IN} <<< FRAC_BITS;
        prod_s     = $signed(vals_r[idx_r]) * $signed(wts_r[idx_r]);
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        shifted_s  = acc_r >>> FRAC_BITS;
        if (USE_RELU && shifted_s[ACC_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = shifted_s;
        end
        if (relu_s > MAX_ACC) begin
            result_s = MAX_W;
        end else if (relu_s < MIN_ACC) begin
            result_s = MIN_W;
        end else begin
            result_s = relu_s[WIDTH-1:0];
        end
    end

    // Next-state and next-register logic for the IDLE -> MAC -> FINISH sequence.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        acc_nxt_s     = acc_r;
        vals_nxt_s    = vals_r;
        wts_nxt_s     = wts_r;
        value_nxt_s   = value_r;
        valid_nxt_s   = 1'b0;
        overrun_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (VALID_IN) begin
                    vals_nxt_s  = VALUES_IN;
                    wts_nxt_s   = WEIGHTS_IN;
                    acc_nxt_s   = bias_ext_s;
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_MAC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_nxt_s = acc_r + prod_ext_s;
                if (idx_r == LAST_IDX) begin
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_FINISH;
                end else begin
                    idx_nxt_s   = idx_r + IDX_ONE;
                    state_nxt_s = ST_MAC;
                end
            end
            ST_FINISH: begin
                value_nxt_s = result_s;
                valid_nxt_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A pulse arriving in any non-idle state is dropped and flagged.
        if (VALID_IN && (state_r != ST_IDLE)) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            acc_r     <= '0;
            vals_r    <= '0;
            wts_r     <= '0;
            value_r   <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            acc_r     <= acc_nxt_s;
            vals_r    <= vals_nxt_s;
            wts_r     <= wts_nxt_s;
            value_r   <= value_nxt_s;
            valid_r   <= valid_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign VALUE_OUT = value_r;
    assign VALID_OUT = valid_r;
    assign OVERRUN   = overrun_r;
    assign BUSY      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: a ReLU and a linear instance share stimulus
// and are compared against an integer reference model of the weighted sum.
module tb_neuron_mac_seq;

    localparam int N = 4;
    localparam int W = 8;
    localparam int F = 5;
    localparam int NONE = -9999;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    vec_t         VALUES_IN = '0;
    vec_t         WEIGHTS_IN = '0;
    logic [W-1:0] BIAS_IN = '0;
    logic         VALID_IN = 1'b0;

    logic [W-1:0] value_rl, value_ln;
    logic         valid_rl, valid_ln, busy_rl, busy_ln, ovr_rl, ovr_ln;

    int n_checks = 0;
    int n_fail = 0;

    neuron_mac_seq #(.NUM_INPUTS(N), .WIDTH(W), .FRAC_BITS(F), .USE_RELU(1'b1)) dut_relu (
        .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
        .WEIGHTS_IN(WEIGHTS_IN), .BIAS_IN(BIAS_IN), .VALUE_OUT(value_rl),
        .VALID_OUT(valid_rl), .BUSY(busy_rl), .OVERRUN(ovr_rl));

    neuron_mac_seq #(.NUM_INPUTS(N), .WIDTH(W), .FRAC_BITS(F), .USE_RELU(1'b0)) dut_lin (
        .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
        .WEIGHTS_IN(WEIGHTS_IN), .BIAS_IN(BIAS_IN), .VALUE_OUT(value_ln),
        .VALID_OUT(valid_ln), .BUSY(busy_ln), .OVERRUN(ovr_ln));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = W'(a0);
        v[1] = W'(a1);
        v[2] = W'(a2);
        v[3] = W'(a3);
        return v;
    endfunction

    // Reference: exact sum, floor division by 2**F, optional clamp at 0, saturation.
    function automatic int model(input vec_t v, input vec_t w, input logic [W-1:0] b, input bit relu);
        int s, q, a, c;
        s = int'($signed(b)) * (1 << F);
        for (int i = 0; i < N; i++) begin
            a = int'($signed(v[i]));
            c = int'($signed(w[i]));
            s = s + a * c;
        end
        q = s / (1 << F);
        if ((s % (1 << F) != 0) && (s < 0)) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic run_op(input string tag, input vec_t v, input vec_t w, input logic [W-1:0] b,
                          input bit chg_cfg, input int fixed_rl, input int fixed_ln);
        int er, el, lat;
        er = model(v, w, b, 1'b1);
        el = model(v, w, b, 1'b0);
        @(negedge CLK);
        VALUES_IN = v; WEIGHTS_IN = w; BIAS_IN = b; VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        if (chg_cfg) begin
            WEIGHTS_IN = '0;
            BIAS_IN = 8'h80;
        end
        check({tag, "_busy"}, busy_rl, 1);
        lat = 0;
        while (!valid_rl && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "_lat"}, lat, N + 1);
        check({tag, "_vld_lin"}, valid_ln, 1);
        check({tag, "_val_relu"}, $signed(value_rl), er);
        check({tag, "_val_lin"}, $signed(value_ln), el);
        if (fixed_rl != NONE) check({tag, "_const_relu"}, $signed(value_rl), fixed_rl);
        if (fixed_ln != NONE) check({tag, "_const_lin"}, $signed(value_ln), fixed_ln);
        @(negedge CLK);
        check({tag, "_vld_pulse"}, valid_rl, 0);
        check({tag, "_idle"}, busy_rl, 0);
        check({tag, "_no_ovr"}, ovr_rl, 0);
    endtask

    initial begin
        vec_t va, vb, vr, wr;
        int ea, eb, ovr_cnt, ovr_k, v_cnt, v_k0, v_k1, val0, val1;
        logic [W-1:0] br;

        // Reset state
        #1;
        check("rst_value", $signed(value_rl), 0);
        check("rst_valid", valid_rl, 0);
        check("rst_busy", busy_rl, 0);
        check("rst_ovr", ovr_rl, 0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Spec scenarios
        run_op("t1", mk(32, 32, 32, 32), mk(16, 16, 16, 16), 8'd0, 1'b0, 64, 64);
        run_op("t2a", mk(32, -32, 64, 0), mk(32, 32, 32, 32), 8'hF0, 1'b0, NONE, 48);
        run_op("t2b", mk(32, -32, 64, 0), mk(32, 32, 32, 32), 8'h80, 1'b0, 0, NONE);
        run_op("t3a", mk(127, 127, 127, 127), mk(127, 127, 127, 127), 8'd127, 1'b0, 127, 127);
        run_op("t3b", mk(127, 127, 127, 127), mk(-128, -128, -128, -128), 8'd0, 1'b0, NONE, -128);

        // Overrun: second pulse two cycles after the first
        va = mk(32, 32, 32, 32);
        vb = mk(-100, 50, 7, 90);
        ea = model(va, mk(16, 16, 16, 16), 8'd0, 1'b0);
        ovr_cnt = 0; ovr_k = 0; v_cnt = 0; v_k0 = 0; val0 = 0;
        @(negedge CLK);
        VALUES_IN = va; WEIGHTS_IN = mk(16, 16, 16, 16); BIAS_IN = 8'd0; VALID_IN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (ovr_rl) begin ovr_cnt++; ovr_k = k; end
            if (valid_ln) begin v_cnt++; v_k0 = k; val0 = $signed(value_ln); end
            if (k == 2) begin
                VALUES_IN = vb; WEIGHTS_IN = mk(3, -5, 9, 11); VALID_IN = 1'b1;
            end else begin
                VALID_IN = 1'b0;
            end
        end
        check("ovr_count", ovr_cnt, 1);
        check("ovr_cycle", ovr_k, 3);
        check("ovr_valid_count", v_cnt, 1);
        check("ovr_valid_cycle", v_k0, N + 2);
        check("ovr_first_value", val0, ea);

        // Back-to-back: pulses exactly N+2 cycles apart
        va = mk(10, -20, 30, -40);
        vb = mk(-64, 64, 100, -3);
        ea = model(va, mk(50, 60, -70, 80), 8'd5, 1'b0);
        eb = model(vb, mk(50, 60, -70, 80), 8'd5, 1'b0);
        ovr_cnt = 0; v_cnt = 0; v_k0 = 0; v_k1 = 0; val0 = 0; val1 = 0;
        @(negedge CLK);
        VALUES_IN = va; WEIGHTS_IN = mk(50, 60, -70, 80); BIAS_IN = 8'd5; VALID_IN = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (ovr_rl || ovr_ln) ovr_cnt++;
            if (valid_ln) begin
                if (v_cnt == 0) begin v_k0 = k; val0 = $signed(value_ln); end
                else begin v_k1 = k; val1 = $signed(value_ln); end
                v_cnt++;
            end
            if (k == N + 2) begin
                VALUES_IN = vb; VALID_IN = 1'b1;
            end else begin
                VALID_IN = 1'b0;
            end
        end
        check("b2b_ovr", ovr_cnt, 0);
        check("b2b_valid_count", v_cnt, 2);
        check("b2b_cycle0", v_k0, N + 2);
        check("b2b_cycle1", v_k1, 2 * (N + 2));
        check("b2b_val0", val0, ea);
        check("b2b_val1", val1, eb);

        // Config stability: weights/bias change one cycle after capture
        run_op("t6", mk(32, 32, 32, 32), mk(16, 16, 16, 16), 8'd0, 1'b1, 64, 64);

        // Reset two cycles after VALID_IN
        @(negedge CLK);
        VALUES_IN = mk(40, 40, 40, 40); WEIGHTS_IN = mk(40, 40, 40, 40); BIAS_IN = 8'd1; VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check("rmid_value", $signed(value_rl), 0);
        check("rmid_value_lin", $signed(value_ln), 0);
        check("rmid_busy", busy_rl, 0);
        check("rmid_valid", valid_rl, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        v_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (valid_rl || valid_ln) v_cnt++;
        end
        check("rmid_no_valid", v_cnt, 0);
        run_op("t5_next", mk(32, 32, 32, 32), mk(16, 16, 16, 16), 8'd0, 1'b0, 64, 64);

        // Randomized operations against the reference model
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                vr[i] = W'($urandom);
                wr[i] = W'($urandom);
            end
            br = W'($urandom);
            run_op($sformatf("rnd%0d", t), vr, wr, br, 1'b0, NONE, NONE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
